// File: rtl/run_last_decoder_if.sv
// Run/last link bundle between the edge encoder (master) and the
// receive-side decoder (slave).
interface run_last_decoder_if #(
   parameter int CNT_W = 8
);
   logic             r;
   logic             f;
   logic             err_clr;
   logic             run;
   logic             busy;
   logic [CNT_W-1:0] len;
   logic             len_vld;
   logic             len_ovf;
   logic             err;
   logic [1:0]       err_code;
   logic             err_any;

   modport master (
      output r, f, err_clr,
      input  run, busy, len, len_vld, len_ovf,
      input  err, err_code, err_any
   );

   modport slave (
      input  r, f, err_clr,
      output run, busy, len, len_vld, len_ovf,
      output err, err_code, err_any
   );
endinterface

// File: rtl/run_last_decoder.sv
// Rebuilds the run level from the r/f edge markers, measures run
// length and flags every protocol violation on the link.
module run_last_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   run_last_decoder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      LAST = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             len_vld_q, len_vld_d;
   logic             len_ovf_q, len_ovf_d;
   logic             err_q, err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             err_any_q, err_any_d;
   logic             run_q, run_d;
   logic             busy_q, busy_d;
   logic             hit;
   logic [1:0]       code;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      len_d     = len_q;
      len_ovf_d = len_ovf_q;
      len_vld_d = 1'b0;
      hit       = 1'b0;
      code      = 2'd0;

      // Collision outranks every per-state decode
      if (bus.r && bus.f) begin
         state_d = IDLE;
         hit     = 1'b1;
         code    = 2'd0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.r) begin
                  state_d = RUN;
                  cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                  ovf_d   = 1'b0;
               end else if (bus.f) begin
                  hit  = 1'b1;
                  code = 2'd1;
               end
            end
            RUN: begin
               if (bus.r) begin
                  if (&cnt_q) ovf_d = 1'b1;
                  else        cnt_d = cnt_q + 1'b1;
               end else if (bus.f) begin
                  state_d   = LAST;
                  len_d     = cnt_q;
                  len_ovf_d = ovf_q;
                  len_vld_d = 1'b1;
               end else begin
                  state_d = IDLE;
                  hit     = 1'b1;
                  code    = 2'd2;
               end
            end
            LAST: begin
               state_d = IDLE;
               if (bus.r || bus.f) begin
                  hit  = 1'b1;
                  code = 2'd3;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      err_d      = hit;
      err_code_d = hit ? code : err_code_q;
      if (hit)              err_any_d = 1'b1;
      else if (bus.err_clr) err_any_d = 1'b0;
      else                  err_any_d = err_any_q;

      run_d  = (state_d == RUN);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         len_q      <= '0;
         len_vld_q  <= 1'b0;
         len_ovf_q  <= 1'b0;
         err_q      <= 1'b0;
         err_code_q <= 2'd0;
         err_any_q  <= 1'b0;
         run_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         len_q      <= len_d;
         len_vld_q  <= len_vld_d;
         len_ovf_q  <= len_ovf_d;
         err_q      <= err_d;
         err_code_q <= err_code_d;
         err_any_q  <= err_any_d;
         run_q      <= run_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.run      = run_q;
   assign bus.busy     = busy_q;
   assign bus.len      = len_q;
   assign bus.len_vld  = len_vld_q;
   assign bus.len_ovf  = len_ovf_q;
   assign bus.err      = err_q;
   assign bus.err_code = err_code_q;
   assign bus.err_any  = err_any_q;

endmodule

// File: tb/tb_run_last_decoder.sv
// Bench for run_last_decoder: event scoreboard on len_vld/err pulses
// plus direct checks of level outputs at key points.
module tb_run_last_decoder;

   localparam int CNT_W = 4;

   typedef struct {
      logic       is_err;
      logic [3:0] len;
      logic       ovf;
      logic [1:0] code;
   } exp_t;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_pass;
   int   run_hi;
   int   run_mark;
   exp_t q[$];

   run_last_decoder_if #(.CNT_W(CNT_W)) bus ();

   run_last_decoder #(.CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic step(input logic rr, input logic ff,
                       input logic cc = 1'b0);
      @(negedge clk);
      bus.r       = rr;
      bus.f       = ff;
      bus.err_clr = cc;
   endtask

   task automatic push_len(input int l, input logic o);
      exp_t e;
      e.is_err = 1'b0;
      e.len    = 4'(l);
      e.ovf    = o;
      e.code   = 2'd0;
      q.push_back(e);
   endtask

   task automatic push_err(input int c);
      exp_t e;
      e.is_err = 1'b1;
      e.len    = 4'd0;
      e.ovf    = 1'b0;
      e.code   = 2'(c);
      q.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic runs(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0);
   endtask

   // Event monitor: every pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.run) run_hi++;
         if (bus.len_vld) begin
            if (q.size() == 0) begin
               chk("unexp_len_vld", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("len_kind", 32'd0, 32'(e.is_err));
               chk("len", 32'(bus.len), 32'(e.len));
               chk("len_ovf", 32'(bus.len_ovf), 32'(e.ovf));
            end
         end
         if (bus.err) begin
            if (q.size() == 0) begin
               chk("unexp_err", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("err_kind", 32'd1, 32'(e.is_err));
               chk("err_code", 32'(bus.err_code), 32'(e.code));
            end
         end
      end
   end

   initial begin
      n_chk       = 0;
      n_pass      = 0;
      run_hi      = 0;
      rst         = 1'b1;
      bus.r       = 1'b0;
      bus.f       = 1'b0;
      bus.err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_outs",
          {bus.run, bus.busy, bus.len, bus.len_vld, bus.len_ovf,
           bus.err, bus.err_code, bus.err_any}, 32'd0);
      rst = 1'b0;

      // Single 5-cycle run
      run_mark = run_hi;
      runs(5);
      step(1'b0, 1'b1);
      push_len(5, 1'b0);
      after_edge();
      chk("last_run", 32'(bus.run), 32'd0);
      chk("last_busy", 32'(bus.busy), 32'd1);
      step(1'b0, 1'b0);
      after_edge();
      chk("idle_busy", 32'(bus.busy), 32'd0);
      step(1'b0, 1'b0);
      chk("run_cycles", 32'(run_hi - run_mark), 32'd5);
      chk("t1_err_any", 32'(bus.err_any), 32'd0);

      // Back-to-back runs with minimum gap
      runs(3);
      step(1'b0, 1'b1);
      push_len(3, 1'b0);
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      push_len(1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("t2_err_any", 32'(bus.err_any), 32'd0);

      // Saturation then a short run
      runs(20);
      step(1'b0, 1'b1);
      push_len(15, 1'b1);
      step(1'b0, 1'b0);
      runs(2);
      step(1'b0, 1'b1);
      push_len(2, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("t3_err_any", 32'(bus.err_any), 32'd0);

      // Orphan f
      step(1'b0, 1'b1);
      push_err(1);
      after_edge();
      chk("orphan_any", 32'(bus.err_any), 32'd1);
      step(1'b0, 1'b0);
      after_edge();
      chk("err_one_cycle", 32'(bus.err), 32'd0);

      // Missing f
      runs(3);
      step(1'b0, 1'b0);
      push_err(2);
      after_edge();
      chk("missing_any", 32'(bus.err_any), 32'd1);
      chk("missing_len", 32'(bus.len), 32'd2);
      step(1'b0, 1'b0);

      // Gap violation: LAST must not re-enter RUN
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      push_len(1, 1'b0);
      step(1'b1, 1'b0);
      push_err(3);
      after_edge();
      chk("gap_busy", 32'(bus.busy), 32'd0);
      chk("gap_any", 32'(bus.err_any), 32'd1);
      step(1'b0, 1'b0);

      // Collision
      step(1'b1, 1'b1);
      push_err(0);
      after_edge();
      chk("coll_code", 32'(bus.err_code), 32'd0);
      chk("coll_any", 32'(bus.err_any), 32'd1);
      step(1'b0, 1'b0);

      // err_clr against a simultaneous error, then alone
      step(1'b0, 1'b1, 1'b1);
      push_err(1);
      after_edge();
      chk("clr_vs_err", 32'(bus.err_any), 32'd1);
      step(1'b0, 1'b0, 1'b1);
      after_edge();
      chk("clr_alone", 32'(bus.err_any), 32'd0);
      step(1'b0, 1'b0);

      // Asynchronous reset on the 4th run cycle
      runs(3);
      @(negedge clk);
      bus.r = 1'b1;
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_outs",
          {bus.run, bus.busy, bus.len, bus.len_vld, bus.len_ovf,
           bus.err, bus.err_code, bus.err_any}, 32'd0);
      @(negedge clk);
      bus.r = 1'b0;
      rst   = 1'b0;
      step(1'b0, 1'b0);
      runs(2);
      step(1'b0, 1'b1);
      push_len(2, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      chk("post_rst_len", 32'(bus.len), 32'd2);
      chk("post_rst_any", 32'(bus.err_any), 32'd0);

      step(1'b0, 1'b0);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
